// File: rtl/mem_stage.sv
// MEM stage of the RISC-8 pipeline: data-memory req/ack access with bounded wait,
// upstream stall generation, branch resolution and the MEM/WB pipeline register.
module mem_stage #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int REG_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              zero_in,
    input  logic [3:0]        alu_flag_in,
    input  logic              memread_in,
    input  logic              memwrite_in,
    input  logic              memtoreg_in,
    input  logic              regwrite_in,
    input  logic              branch_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic              pc_src,
    output logic              mem_err,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [REG_W-1:0]  wb_rd,
    output logic [3:0]        wb_alu_flag,
    output logic              wb_memtoreg,
    output logic              wb_regwrite,
    output logic              wb_valid
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                req_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                err_r;
    logic [DATA_W-1:0]   wb_read_data_r;
    logic [DATA_W-1:0]   wb_alu_result_r;
    logic [REG_W-1:0]    wb_rd_r;
    logic [3:0]          wb_alu_flag_r;
    logic                wb_memtoreg_r;
    logic                wb_regwrite_r;
    logic                wb_valid_r;

    logic                mem_op_s;
    logic                timeout_s;
    logic                stall_s;
    logic                load_done_s;

    // Stall / timeout decode from current state and handshake inputs
    always_comb begin
        mem_op_s    = memread_in | memwrite_in;
        timeout_s   = 1'b0;
        stall_s     = 1'b0;
        load_done_s = 1'b0;
        if (state_r == ST_ACCESS) begin
            timeout_s   = ~dmem_ack & (cnt_r == CNT_LAST);
            stall_s     = ~dmem_ack & ~timeout_s;
            load_done_s = dmem_ack & ~we_r;
        end else begin
            stall_s = mem_op_s;
        end
    end

    // Access FSM: owns the memory request, latched address/data and the wait counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s) begin
                        // A simultaneous read+write request resolves to a store
                        state_r <= ST_ACCESS;
                        req_r   <= 1'b1;
                        we_r    <= memwrite_in;
                        addr_r  <= alu_result_in[ADDR_W-1:0];
                        wdata_r <= rd2_in;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end else if (timeout_s) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                        err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the EX/MEM fields
    always_ff @(posedge clk) begin
        if (!reset_n || stall_s) begin
            wb_read_data_r  <= {DATA_W{1'b0}};
            wb_alu_result_r <= {DATA_W{1'b0}};
            wb_rd_r         <= {REG_W{1'b0}};
            wb_alu_flag_r   <= 4'h0;
            wb_memtoreg_r   <= 1'b0;
            wb_regwrite_r   <= 1'b0;
            wb_valid_r      <= 1'b0;
        end else begin
            wb_read_data_r  <= load_done_s ? dmem_rdata : {DATA_W{1'b0}};
            wb_alu_result_r <= alu_result_in;
            wb_rd_r         <= rd_in;
            wb_alu_flag_r   <= alu_flag_in;
            wb_memtoreg_r   <= memtoreg_in;
            wb_regwrite_r   <= regwrite_in & ~timeout_s;
            wb_valid_r      <= 1'b1;
        end
    end

    assign dmem_req      = req_r;
    assign dmem_we       = we_r;
    assign dmem_addr     = addr_r;
    assign dmem_wdata    = wdata_r;
    assign stall         = stall_s;
    assign pc_src        = branch_in & zero_in;
    assign mem_err       = err_r;
    assign wb_read_data  = wb_read_data_r;
    assign wb_alu_result = wb_alu_result_r;
    assign wb_rd         = wb_rd_r;
    assign wb_alu_flag   = wb_alu_flag_r;
    assign wb_memtoreg   = wb_memtoreg_r;
    assign wb_regwrite   = wb_regwrite_r;
    assign wb_valid      = wb_valid_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: ALU pass-through, store, load, timeout,
// reset mid-access and branch resolution.
module tb_mem_stage;

    logic       clk;
    logic       reset_n;
    logic [7:0] alu_result_in;
    logic [7:0] rd2_in;
    logic [2:0] rd_in;
    logic       zero_in;
    logic [3:0] alu_flag_in;
    logic       memread_in;
    logic       memwrite_in;
    logic       memtoreg_in;
    logic       regwrite_in;
    logic       branch_in;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;
    logic       dmem_ack;
    logic       stall;
    logic       pc_src;
    logic       mem_err;
    logic [7:0] wb_read_data;
    logic [7:0] wb_alu_result;
    logic [2:0] wb_rd;
    logic [3:0] wb_alu_flag;
    logic       wb_memtoreg;
    logic       wb_regwrite;
    logic       wb_valid;

    int n_vec_r;
    int n_err_r;
    int stall_cnt_r;
    int req_cnt_r;

    mem_stage #(.DATA_W(8), .ADDR_W(8), .REG_W(3), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_result_in(alu_result_in), .rd2_in(rd2_in), .rd_in(rd_in),
        .zero_in(zero_in), .alu_flag_in(alu_flag_in),
        .memread_in(memread_in), .memwrite_in(memwrite_in),
        .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .branch_in(branch_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .pc_src(pc_src), .mem_err(mem_err),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
        .wb_alu_flag(wb_alu_flag), .wb_memtoreg(wb_memtoreg),
        .wb_regwrite(wb_regwrite), .wb_valid(wb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count stalled and requesting cycles mid-period, away from the active edge
    always @(negedge clk) begin
        if (stall) stall_cnt_r = stall_cnt_r + 1;
        if (dmem_req) req_cnt_r = req_cnt_r + 1;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec_r = n_vec_r + 1;
        if (obs !== exp) begin
            n_err_r = n_err_r + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] alu, input logic [7:0] rd2, input logic [2:0] rd,
                          input logic rd_en, input logic wr_en, input logic m2r, input logic rw);
        alu_result_in = alu;
        rd2_in        = rd2;
        rd_in         = rd;
        memread_in    = rd_en;
        memwrite_in   = wr_en;
        memtoreg_in   = m2r;
        regwrite_in   = rw;
    endtask

    task automatic chk_bubble(input string tag);
        chk_val({tag, "_valid"}, {31'd0, wb_valid}, 32'd0);
        chk_val({tag, "_rw"}, {31'd0, wb_regwrite}, 32'd0);
        chk_val({tag, "_alu"}, {24'd0, wb_alu_result}, 32'd0);
    endtask

    initial begin
        n_vec_r = 0; n_err_r = 0; stall_cnt_r = 0; req_cnt_r = 0;
        reset_n = 1'b0; zero_in = 1'b0; branch_in = 1'b0; alu_flag_in = 4'h0;
        dmem_rdata = 8'h00; dmem_ack = 1'b0;
        set_op(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk_val("rst_req", {31'd0, dmem_req}, 32'd0);
        chk_val("rst_err", {31'd0, mem_err}, 32'd0);
        chk_val("rst_stall", {31'd0, stall}, 32'd0);
        chk_bubble("rst_wb");
        reset_n = 1'b1;

        // ALU op passes through with latency 1
        stall_cnt_r = 0;
        set_op(8'h3C, 8'h00, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_flag_in = 4'h3;
        tick();
        chk_val("alu_res", {24'd0, wb_alu_result}, 32'h3C);
        chk_val("alu_rd", {29'd0, wb_rd}, 32'd5);
        chk_val("alu_valid", {31'd0, wb_valid}, 32'd1);
        chk_val("alu_rw", {31'd0, wb_regwrite}, 32'd1);
        chk_val("alu_flag", {28'd0, wb_alu_flag}, 32'h3);
        chk_val("alu_rdata", {24'd0, wb_read_data}, 32'd0);
        chk_val("alu_stalls", stall_cnt_r, 32'd0);
        alu_flag_in = 4'h0;

        // Store 0xA5 to 0x10, ack one cycle after req
        stall_cnt_r = 0;
        set_op(8'h10, 8'hA5, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        #1 chk_val("st_stall0", {31'd0, stall}, 32'd1);
        tick();
        chk_val("st_req", {31'd0, dmem_req}, 32'd1);
        chk_val("st_we", {31'd0, dmem_we}, 32'd1);
        chk_val("st_addr", {24'd0, dmem_addr}, 32'h10);
        chk_val("st_wdata", {24'd0, dmem_wdata}, 32'hA5);
        chk_bubble("st_bub");
        tick();
        chk_val("st_hold_addr", {24'd0, dmem_addr}, 32'h10);
        dmem_ack = 1'b1; dmem_rdata = 8'hEE;
        #1 chk_val("st_stall_ack", {31'd0, stall}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        set_op(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_val("st_req_drop", {31'd0, dmem_req}, 32'd0);
        chk_val("st_valid", {31'd0, wb_valid}, 32'd1);
        chk_val("st_rw", {31'd0, wb_regwrite}, 32'd1);
        chk_val("st_rdata", {24'd0, wb_read_data}, 32'd0);
        chk_val("st_wbaddr", {24'd0, wb_alu_result}, 32'h10);
        #5;
        chk_val("st_stalls", stall_cnt_r, 32'd2);

        // Load from 0x20, ack after three ACCESS cycles
        @(posedge clk); #1;
        stall_cnt_r = 0;
        set_op(8'h20, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk_val("ld_req", {31'd0, dmem_req}, 32'd1);
        chk_val("ld_we", {31'd0, dmem_we}, 32'd0);
        chk_val("ld_addr", {24'd0, dmem_addr}, 32'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_bubble("ld_bub");
            chk_val("ld_req_hold", {31'd0, dmem_req}, 32'd1);
        end
        dmem_ack = 1'b1; dmem_rdata = 8'h7E;
        tick();
        dmem_ack = 1'b0; dmem_rdata = 8'h00;
        set_op(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_val("ld_rdata", {24'd0, wb_read_data}, 32'h7E);
        chk_val("ld_m2r", {31'd0, wb_memtoreg}, 32'd1);
        chk_val("ld_valid", {31'd0, wb_valid}, 32'd1);
        chk_val("ld_rd", {29'd0, wb_rd}, 32'd3);
        chk_val("ld_req_drop", {31'd0, dmem_req}, 32'd0);
        #5;
        chk_val("ld_stalls", stall_cnt_r, 32'd4);

        // Load without ack times out after 16 request cycles
        @(posedge clk); #1;
        stall_cnt_r = 0; req_cnt_r = 0;
        set_op(8'h44, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!dmem_req) break;
        end
        set_op(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_val("to_req_drop", {31'd0, dmem_req}, 32'd0);
        chk_val("to_req_cycles", req_cnt_r, 32'd16);
        chk_val("to_err", {31'd0, mem_err}, 32'd1);
        chk_val("to_rw", {31'd0, wb_regwrite}, 32'd0);
        chk_val("to_valid", {31'd0, wb_valid}, 32'd1);
        chk_val("to_rdata", {24'd0, wb_read_data}, 32'd0);
        #1 chk_val("to_stall_rel", {31'd0, stall}, 32'd0);
        #4;
        chk_val("to_stalls", stall_cnt_r, 32'd16);
        tick();
        chk_val("to_err_sticky", {31'd0, mem_err}, 32'd1);

        // Both read and write requested: treated as a store
        set_op(8'h55, 8'h66, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_val("rw_we", {31'd0, dmem_we}, 32'd1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        set_op(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-access, then a late ack is ignored
        set_op(8'h30, 8'h11, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_val("mr_req", {31'd0, dmem_req}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_op(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_val("mr_req", {31'd0, dmem_req}, 32'd0);
        chk_val("mr_stall", {31'd0, stall}, 32'd0);
        chk_val("mr_err", {31'd0, mem_err}, 32'd0);
        chk_bubble("mr_wb");
        dmem_ack = 1'b1; dmem_rdata = 8'hFF;
        tick();
        dmem_ack = 1'b0;
        chk_val("late_req", {31'd0, dmem_req}, 32'd0);
        chk_val("late_rdata", {24'd0, wb_read_data}, 32'd0);
        chk_val("late_err", {31'd0, mem_err}, 32'd0);

        // Branch resolution is combinational
        branch_in = 1'b1; zero_in = 1'b1;
        #1 chk_val("br_taken", {31'd0, pc_src}, 32'd1);
        zero_in = 1'b0;
        #1 chk_val("br_not_taken", {31'd0, pc_src}, 32'd0);
        branch_in = 1'b0; zero_in = 1'b1;
        #1 chk_val("br_nobranch", {31'd0, pc_src}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec_r, n_err_r);
        $finish;
    end

endmodule
